// File: rtl/rtc_campos_pkg.sv
// Shared codes, state encoding and BCD field limits for the RTC field editor.
package rtc_campos_pkg;

    // Clock groups; the same code drives edit mode, read group and write group.
    typedef enum logic [1:0] {
        GRP_NONE  = 2'b00,
        GRP_TIMER = 2'b01,
        GRP_FECHA = 2'b10,
        GRP_HORA  = 2'b11
    } grp_e;

    // Cursor position; field0 is the leftmost byte of a group.
    typedef enum logic [1:0] {
        POS_NONE = 2'b00,
        POS_F2   = 2'b01,
        POS_F1   = 2'b10,
        POS_F0   = 2'b11
    } pos_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EDIT  = 2'b01,
        ST_WRITE = 2'b10
    } state_e;

    // Time and timer share hh:mm:ss limits.
    localparam logic [7:0] HH_MIN = 8'h00;
    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MS_MIN = 8'h00;
    localparam logic [7:0] MS_MAX = 8'h59;

    // Date limits; the upper day and year limits come from module parameters.
    localparam logic [7:0] DD_MIN = 8'h01;
    localparam logic [7:0] MO_MIN = 8'h01;
    localparam logic [7:0] MO_MAX = 8'h12;
    localparam logic [7:0] YY_MIN = 8'h00;

    localparam logic [23:0] HMS_RESET   = 24'h000000;
    localparam logic [23:0] FECHA_RESET = 24'h010100;

    // Byte of a group under the cursor.
    function automatic logic [7:0] campo(input logic [23:0] grp, input pos_e pos);
        logic [7:0] r;
        case (pos)
            POS_F0:  r = grp[23:16];
            POS_F1:  r = grp[15:8];
            POS_F2:  r = grp[7:0];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Group with the byte under the cursor replaced.
    function automatic logic [23:0] pon_campo(input logic [23:0] grp, input pos_e pos,
                                              input logic [7:0] val);
        logic [23:0] r;
        r = grp;
        case (pos)
            POS_F0:  r[23:16] = val;
            POS_F1:  r[15:8]  = val;
            POS_F2:  r[7:0]   = val;
            default: r = grp;
        endcase
        return r;
    endfunction

    // Shadow of one group; anything that is not timer or date selects time.
    function automatic logic [23:0] sombra(input grp_e g, input logic [23:0] timer,
                                           input logic [23:0] fecha, input logic [23:0] hora);
        logic [23:0] r;
        case (g)
            GRP_TIMER: r = timer;
            GRP_FECHA: r = fecha;
            default:   r = hora;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/editor_campos_rtc_bcd_paso.sv
// One BCD up/down step of a byte field with wrap-around between min and max.
module bcd_paso (
    input  logic [7:0] valor,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    input  logic       up,
    input  logic       down,
    output logic [7:0] salida
);

    logic valido;

    // Step the field; out-of-range or non-BCD values restart at the minimum.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        salida = valor;
        valido = (valor[3:0] <= 4'd9) && (valor[7:4] <= 4'd9) &&
                 (valor >= min_val) && (valor <= max_val);
        if (up && !down) begin
            if (!valido || valor == max_val) begin
                salida = min_val;
            end else if (valor[3:0] == 4'd9) begin
                salida = {valor[7:4] + 4'd1, 4'd0};
            end else begin
                salida = valor + 8'd1;
            end
        end else if (down && !up) begin
            if (!valido) begin
                salida = min_val;
            end else if (valor == min_val) begin
                salida = max_val;
            end else if (valor[3:0] == 4'd0) begin
                salida = {valor[7:4] - 4'd1, 4'd9};
            end else begin
                salida = valor - 8'd1;
            end
        end
    end

endmodule

// File: rtl/editor_campos_rtc.sv
// Field editor for the RTC groups: button stepping, shadow copies, write-back.
module editor_campos_rtc
    import rtc_campos_pkg::*;
#(
    parameter logic [7:0] DAY_MAX  = 8'h31,
    parameter logic [7:0] YEAR_MAX = 8'h99
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  fsm_edit,
    input  logic [1:0]  fsm_pos,
    input  logic        boton_up,
    input  logic        boton_down,
    input  logic        rd_valid,
    input  logic [1:0]  rd_grupo,
    input  logic [23:0] rd_dato,
    output logic        wr_req,
    output logic [1:0]  wr_grupo,
    output logic [23:0] wr_dato,
    input  logic        wr_ack,
    output logic [23:0] disp_dato,
    output logic        editando
);

    // Button path, bit 0 = up, bit 1 = down.
    logic [1:0]  btn_s1_q, btn_s1_d;
    logic [1:0]  btn_s2_q, btn_s2_d;
    logic [1:0]  btn_prev_q, btn_prev_d;
    logic [1:0]  pulso_q, pulso_d;

    state_e      state_q, state_d;
    grp_e        grupo_q, grupo_d;
    logic        dirty_q, dirty_d;
    logic        wr_req_q, wr_req_d;
    logic [1:0]  wr_grupo_q, wr_grupo_d;
    logic [23:0] wr_dato_q, wr_dato_d;
    logic [23:0] timer_q, timer_d;
    logic [23:0] fecha_q, fecha_d;
    logic [23:0] hora_q, hora_d;

    pos_e        pos;
    logic [23:0] sombra_edit;
    logic [23:0] editado;
    logic [7:0]  paso_in, paso_out, lim_min, lim_max;
    logic        paso_en;

    assign pos = pos_e'(fsm_pos);

    // Synchronise both buttons and turn each rising edge into a one-cycle pulse.
    always_comb begin
        btn_s1_d   = {boton_down, boton_up};
        btn_s2_d   = btn_s1_q;
        btn_prev_d = btn_s2_q;
        pulso_d    = btn_s2_q & ~btn_prev_q;
    end

    // Select the field under the cursor of the edited group and its limits.
    always_comb begin
        sombra_edit = sombra(grupo_q, timer_q, fecha_q, hora_q);
        paso_in     = campo(sombra_edit, pos);
        lim_min     = HH_MIN;
        lim_max     = HH_MAX;
        if (grupo_q == GRP_FECHA) begin
            case (pos)
                POS_F0:  begin lim_min = DD_MIN; lim_max = DAY_MAX;  end
                POS_F1:  begin lim_min = MO_MIN; lim_max = MO_MAX;   end
                default: begin lim_min = YY_MIN; lim_max = YEAR_MAX; end
            endcase
        end else if (pos != POS_F0) begin
            lim_min = MS_MIN;
            lim_max = MS_MAX;
        end
    end

    bcd_paso u_paso (
        .valor   (paso_in),
        .min_val (lim_min),
        .max_val (lim_max),
        .up      (pulso_q[0]),
        .down    (pulso_q[1]),
        .salida  (paso_out)
    );

    // Shadow updates (read data, then edits) and the session/write FSM.
    always_comb begin
        state_d    = state_q;
        grupo_d    = grupo_q;
        dirty_d    = dirty_q;
        wr_req_d   = wr_req_q;
        wr_grupo_d = wr_grupo_q;
        wr_dato_d  = wr_dato_q;
        timer_d    = timer_q;
        fecha_d    = fecha_q;
        hora_d     = hora_q;
        editado    = pon_campo(sombra_edit, pos, paso_out);
        paso_en    = (state_q == ST_EDIT) && (pos != POS_NONE) && (pulso_q[0] ^ pulso_q[1]);

        // The group owned by an open session never takes read data.
        if (rd_valid && !((state_q != ST_IDLE) && (rd_grupo == grupo_q))) begin
            case (grp_e'(rd_grupo))
                GRP_TIMER: timer_d = rd_dato;
                GRP_FECHA: fecha_d = rd_dato;
                GRP_HORA:  hora_d  = rd_dato;
                default:   ;
            endcase
        end

        if (paso_en) begin
            dirty_d = 1'b1;
            case (grupo_q)
                GRP_TIMER: timer_d = editado;
                GRP_FECHA: fecha_d = editado;
                default:   hora_d  = editado;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (fsm_edit != GRP_NONE) begin
                    state_d = ST_EDIT;
                    grupo_d = grp_e'(fsm_edit);
                    dirty_d = 1'b0;
                end
            end
            ST_EDIT: begin
                if (fsm_edit != grupo_q) begin
                    if (dirty_d) begin
                        state_d    = ST_WRITE;
                        wr_req_d   = 1'b1;
                        wr_grupo_d = grupo_q;
                        wr_dato_d  = sombra(grupo_q, timer_d, fecha_d, hora_d);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_ack) begin
                    state_d  = ST_IDLE;
                    wr_req_d = 1'b0;
                    dirty_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops any pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1_q   <= 2'b00;
            btn_s2_q   <= 2'b00;
            btn_prev_q <= 2'b00;
            pulso_q    <= 2'b00;
            state_q    <= ST_IDLE;
            grupo_q    <= GRP_NONE;
            dirty_q    <= 1'b0;
            wr_req_q   <= 1'b0;
            wr_grupo_q <= 2'b00;
            wr_dato_q  <= 24'h000000;
            // NOTE: the shadows are plain registers, not a RAM, so they take a defined reset value.
            timer_q    <= HMS_RESET;
            fecha_q    <= FECHA_RESET;
            hora_q     <= HMS_RESET;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            btn_prev_q <= btn_prev_d;
            pulso_q    <= pulso_d;
            state_q    <= state_d;
            grupo_q    <= grupo_d;
            dirty_q    <= dirty_d;
            wr_req_q   <= wr_req_d;
            wr_grupo_q <= wr_grupo_d;
            wr_dato_q  <= wr_dato_d;
            timer_q    <= timer_d;
            fecha_q    <= fecha_d;
            hora_q     <= hora_d;
        end
    end

    // Display path follows the edit mode directly; mode 00 shows the time.
    always_comb begin
        disp_dato = sombra(grp_e'(fsm_edit), timer_q, fecha_q, hora_q);
    end

    assign wr_req   = wr_req_q;
    assign wr_grupo = wr_grupo_q;
    assign wr_dato  = wr_dato_q;
    assign editando = (state_q == ST_EDIT);

endmodule

// File: tb/tb_editor_campos_rtc.sv
// Scoreboard bench for editor_campos_rtc: expectations queued with stimulus, drained on sampling.
module tb_editor_campos_rtc;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  fsm_edit, fsm_pos;
    logic        boton_up, boton_down;
    logic        rd_valid;
    logic [1:0]  rd_grupo;
    logic [23:0] rd_dato;
    logic        wr_req;
    logic [1:0]  wr_grupo;
    logic [23:0] wr_dato;
    logic        wr_ack;
    logic [23:0] disp_dato;
    logic        editando;

    localparam int SIG_DISP = 0;
    localparam int SIG_REQ  = 1;
    localparam int SIG_GRP  = 2;
    localparam int SIG_DATO = 3;
    localparam int SIG_EDIT = 4;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    editor_campos_rtc dut (
        .clk        (clk),
        .reset      (reset),
        .fsm_edit   (fsm_edit),
        .fsm_pos    (fsm_pos),
        .boton_up   (boton_up),
        .boton_down (boton_down),
        .rd_valid   (rd_valid),
        .rd_grupo   (rd_grupo),
        .rd_dato    (rd_dato),
        .wr_req     (wr_req),
        .wr_grupo   (wr_grupo),
        .wr_dato    (wr_dato),
        .wr_ack     (wr_ack),
        .disp_dato  (disp_dato),
        .editando   (editando)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            SIG_DISP: return {8'h00, disp_dato};
            SIG_REQ:  return {31'd0, wr_req};
            SIG_GRP:  return {30'd0, wr_grupo};
            SIG_DATO: return {8'h00, wr_dato};
            default:  return {31'd0, editando};
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sig, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sig), e.exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic up, input logic dn);
        boton_up   = up;
        boton_down = dn;
        tick(5);
        boton_up   = 1'b0;
        boton_down = 1'b0;
        tick(4);
    endtask

    task automatic rd_load(input logic [1:0] g, input logic [23:0] d);
        rd_valid = 1'b1;
        rd_grupo = g;
        rd_dato  = d;
        tick(1);
        rd_valid = 1'b0;
        rd_grupo = 2'b00;
        rd_dato  = 24'h0;
    endtask

    task automatic ack_write();
        wr_ack = 1'b1;
        tick(1);
        wr_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; fsm_edit = 2'b00; fsm_pos = 2'b00;
        boton_up = 1'b0; boton_down = 1'b0; rd_valid = 1'b0;
        rd_grupo = 2'b00; rd_dato = 24'h0; wr_ack = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);

        expect_out("rst_wr_req", SIG_REQ, 0);
        expect_out("rst_disp", SIG_DISP, 24'h000000);
        expect_out("rst_editando", SIG_EDIT, 0);
        expect_out("rst_wr_grupo", SIG_GRP, 0);
        expect_out("rst_wr_dato", SIG_DATO, 0);
        drain();

        fsm_edit = 2'b10; #1;
        expect_out("rst_disp_fecha", SIG_DISP, 24'h010100);
        drain();
        tick(1);
        expect_out("enter_edit", SIG_EDIT, 1);
        drain();
        fsm_edit = 2'b00;
        tick(1);
        expect_out("leave_clean_edit", SIG_EDIT, 0);
        expect_out("leave_clean_req", SIG_REQ, 0);
        drain();

        // Date session.
        rd_load(2'b10, 24'h010109);
        fsm_edit = 2'b10; #1;
        expect_out("rd_idle_fecha", SIG_DISP, 24'h010109);
        drain();
        fsm_pos = 2'b10;
        tick(1);
        press(1'b0, 1'b1);
        expect_out("mo_down_wrap", SIG_DISP, 24'h011209);
        drain();
        fsm_pos = 2'b01;
        press(1'b1, 1'b0);
        expect_out("yy_up_carry", SIG_DISP, 24'h011210);
        drain();
        press(1'b1, 1'b1);
        expect_out("up_down_together", SIG_DISP, 24'h011210);
        drain();
        fsm_edit = 2'b00; fsm_pos = 2'b00;
        tick(1);
        expect_out("fecha_wr_req", SIG_REQ, 1);
        expect_out("fecha_wr_grupo", SIG_GRP, 2'b10);
        expect_out("fecha_wr_dato", SIG_DATO, 24'h011210);
        drain();
        ack_write();
        expect_out("fecha_ack_req", SIG_REQ, 0);
        drain();

        // Time session A: wrap and latency.
        rd_load(2'b11, 24'h230000);
        expect_out("rd_idle_hora", SIG_DISP, 24'h230000);
        drain();
        fsm_edit = 2'b11; fsm_pos = 2'b11;
        tick(1);
        boton_up = 1'b1;
        tick(3);
        expect_out("hh_up_before_n3", SIG_DISP, 24'h230000);
        drain();
        tick(1);
        expect_out("hh_up_wrap_n3", SIG_DISP, 24'h000000);
        drain();
        tick(3);
        expect_out("hh_held_one_step", SIG_DISP, 24'h000000);
        drain();
        boton_up = 1'b0;
        tick(4);
        press(1'b0, 1'b1);
        expect_out("hh_down_wrap", SIG_DISP, 24'h230000);
        drain();
        rd_load(2'b11, 24'h111111);
        expect_out("rd_blocked_in_edit", SIG_DISP, 24'h230000);
        drain();
        fsm_edit = 2'b00; fsm_pos = 2'b00;
        tick(1);
        expect_out("hora_a_wr_dato", SIG_DATO, 24'h230000);
        drain();
        ack_write();

        // Time session B: edit to 12:34:56 and hold the request.
        rd_load(2'b11, 24'h113355);
        expect_out("rd_idle_hora_b", SIG_DISP, 24'h113355);
        drain();
        fsm_edit = 2'b11; fsm_pos = 2'b11;
        tick(1);
        press(1'b1, 1'b0);
        fsm_pos = 2'b10;
        press(1'b1, 1'b0);
        fsm_pos = 2'b01;
        press(1'b1, 1'b0);
        expect_out("hora_123456", SIG_DISP, 24'h123456);
        drain();
        fsm_edit = 2'b00; fsm_pos = 2'b00;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("hold_req_%0d", i), SIG_REQ, 1);
            expect_out($sformatf("hold_grp_%0d", i), SIG_GRP, 2'b11);
            expect_out($sformatf("hold_dato_%0d", i), SIG_DATO, 24'h123456);
            drain();
            tick(1);
        end
        ack_write();
        expect_out("ack_req_low", SIG_REQ, 0);
        expect_out("ack_idle", SIG_EDIT, 0);
        drain();

        // Timer session without presses: no write.
        fsm_edit = 2'b01;
        tick(1);
        expect_out("timer_edit", SIG_EDIT, 1);
        expect_out("timer_disp", SIG_DISP, 24'h000000);
        drain();
        fsm_edit = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            expect_out($sformatf("timer_no_req_%0d", i), SIG_REQ, 0);
            drain();
        end

        // Reset during a pending write.
        fsm_edit = 2'b01; fsm_pos = 2'b01;
        tick(1);
        press(1'b1, 1'b0);
        expect_out("timer_ss_up", SIG_DISP, 24'h000001);
        drain();
        fsm_edit = 2'b00; fsm_pos = 2'b00;
        tick(1);
        expect_out("timer_wr_req", SIG_REQ, 1);
        expect_out("timer_wr_grupo", SIG_GRP, 2'b01);
        drain();
        #2 reset = 1'b0;
        #1;
        expect_out("async_rst_req", SIG_REQ, 0);
        expect_out("async_rst_dato", SIG_DATO, 0);
        expect_out("async_rst_hora", SIG_DISP, 24'h000000);
        drain();
        tick(1);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            expect_out($sformatf("no_retry_%0d", i), SIG_REQ, 0);
            drain();
        end
        fsm_edit = 2'b01; #1;
        expect_out("timer_after_rst", SIG_DISP, 24'h000000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
